pc_fetch: RTL and testbench

- Program-counter and fetch sequencer directly upstream of the 128x8 instruction ROM.
- Drives the ROM's 7-bit address from a registered PC.
- Advances the PC sequentially, by relative branch, or by absolute jump, under control of the decode stage.
- Handles start, stall and halt, and reports program completion to the testbench/top level.

---
 rtl/pc_fetch_pkg.sv | 22 ++
 rtl/pc_fetch_if.sv | 38 +++
 rtl/pc_fetch_pc_next_logic.sv | 43 ++++
 rtl/pc_fetch.sv | 100 ++++++++++
 tb/tb_pc_fetch.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// +-----------------------------------------------------------------------+
// | fetch_pkg : shared widths, FSM state type and reset PC for pc_fetch.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam int PC_W_DEF  = 7;
  localparam int OFF_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PC_W_DEF-1:0] PC_RESET = '0;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_if.sv
// +-----------------------------------------------------------------------+
// | pc_fetch_if : decode-side control bus and ROM-side outputs of pc_fetch.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface pc_fetch_if #(
  parameter int PC_W  = 7,
  parameter int OFF_W = 5
);

  logic             start_i;
  logic [PC_W-1:0]  start_addr_i;
  logic             stall_i;
  logic             halt_i;
  logic             jump_en_i;
  logic [PC_W-1:0]  jump_target_i;
  logic             branch_taken_i;
  logic [OFF_W-1:0] branch_off_i;
  logic [PC_W-1:0]  pc_o;
  logic             valid_o;
  logic             done_o;

  modport master (
    output start_i, start_addr_i, stall_i, halt_i, jump_en_i,
           jump_target_i, branch_taken_i, branch_off_i,
    input  pc_o, valid_o, done_o
  );

  modport slave (
    input  start_i, start_addr_i, stall_i, halt_i, jump_en_i,
           jump_target_i, branch_taken_i, branch_off_i,
    output pc_o, valid_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/pc_fetch_pc_next_logic.sv
// +-----------------------------------------------------------------------+
// | pc_next_logic : RUN-state next-PC priority mux (halt/stall/jump/branch)|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module pc_next_logic #(
  parameter int PC_W  = 7,
  parameter int OFF_W = 5
) (
  input  wire logic [PC_W-1:0]  pc_i,
  input  wire logic             halt_i,
  input  wire logic             stall_i,
  input  wire logic             jump_en_i,
  input  wire logic [PC_W-1:0]  jump_target_i,
  input  wire logic             branch_taken_i,
  input  wire logic [OFF_W-1:0] branch_off_i,
  output logic      [PC_W-1:0]  next_pc_o
);

  logic [PC_W-1:0] off_sext;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;

  // Sign-extended offset; the adders wrap naturally at PC_W bits.
  assign off_sext = {{(PC_W-OFF_W){branch_off_i[OFF_W-1]}}, branch_off_i};
  assign pc_inc   = pc_i + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc_br    = pc_i + off_sext;

  always_comb begin
    next_pc_o = pc_inc;
    if (halt_i || stall_i) begin
      next_pc_o = pc_i;
    end else if (jump_en_i) begin
      next_pc_o = jump_target_i;
    end else if (branch_taken_i) begin
      next_pc_o = pc_br;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch.sv
// +-----------------------------------------------------------------------+
// | pc_fetch : PC register and IDLE/RUN/DONE fetch sequencer for the ROM.  |
// | Option PC_FETCH_CYCLE_COUNT_EN adds a saturating RUN-cycle counter.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module pc_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) (
  input  wire logic   clk_i,
  input  wire logic   reset_i,
  pc_fetch_if.slave   bus
`ifdef PC_FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0] cycle_cnt_o
`endif
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] run_next_pc;
  logic            start_acc;

  pc_next_logic #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next (
    .pc_i           (pc_q),
    .halt_i         (bus.halt_i),
    .stall_i        (bus.stall_i),
    .jump_en_i      (bus.jump_en_i),
    .jump_target_i  (bus.jump_target_i),
    .branch_taken_i (bus.branch_taken_i),
    .branch_off_i   (bus.branch_off_i),
    .next_pc_o      (run_next_pc)
  );

  assign start_acc = bus.start_i && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          pc_d    = bus.start_addr_i;
          state_d = RUN;
        end
      end
      RUN: begin
        pc_d = run_next_pc;
        if (bus.halt_i) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = PC_W'(PC_RESET);
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(PC_RESET);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.pc_o    = pc_q;
  assign bus.valid_o = (state_q == RUN);
  assign bus.done_o  = (state_q == DONE);

`ifdef PC_FETCH_CYCLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || start_acc) begin
      cnt_q <= '0;
    end else if (state_q == RUN && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_cnt_o = cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; expected values are hand-computed.
`default_nettype none

module tb_pc_fetch;

  logic clk_i;
  logic reset_i;
  int   n_chk;
  int   n_pass;

  pc_fetch_if #(.PC_W(7), .OFF_W(5)) bus ();

`ifdef PC_FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_o;
`endif

  pc_fetch #(.PC_W(7), .OFF_W(5)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .bus         (bus.slave)
`ifdef PC_FETCH_CYCLE_COUNT_EN
    ,
    .cycle_cnt_o (cycle_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_ctl();
    bus.start_i        = 1'b0;
    bus.stall_i        = 1'b0;
    bus.halt_i         = 1'b0;
    bus.jump_en_i      = 1'b0;
    bus.branch_taken_i = 1'b0;
  endtask

  task automatic jump_to(input int tgt);
    bus.jump_en_i     = 1'b1;
    bus.jump_target_i = 7'(tgt);
    step();
    idle_ctl();
  endtask

  task automatic check_state(input string tag, input int pc, input int v, input int d);
    chk({tag, ".pc"},    int'(bus.pc_o),    pc);
    chk({tag, ".valid"}, int'(bus.valid_o), v);
    chk({tag, ".done"},  int'(bus.done_o),  d);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle_ctl();
    bus.start_addr_i  = '0;
    bus.jump_target_i = '0;
    bus.branch_off_i  = '0;
    reset_i = 1'b1;
    step();
    step();
    check_state("reset", 0, 0, 0);
    reset_i = 1'b0;

    // Controls other than start are ignored in IDLE.
    bus.jump_en_i = 1'b1; bus.jump_target_i = 7'd50; bus.halt_i = 1'b1;
    step();
    idle_ctl();
    check_state("idle_ign", 0, 0, 0);

    bus.start_i = 1'b1; bus.start_addr_i = 7'd10;
    step();
    idle_ctl();
    check_state("start10", 10, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_state($sformatf("seq%0d", i), 10 + i, 1, 0);
    end

    jump_to(20);
    chk("jump20", int'(bus.pc_o), 20);
    bus.branch_taken_i = 1'b1; bus.branch_off_i = 5'b11011;
    step();
    idle_ctl();
    chk("br_m5", int'(bus.pc_o), 15);
    bus.branch_taken_i = 1'b1; bus.branch_off_i = 5'b00011;
    jump_to(100);
    chk("jmp_beats_br", int'(bus.pc_o), 100);
    bus.branch_taken_i = 1'b1; bus.branch_off_i = 5'b01111;
    step();
    idle_ctl();
    chk("br_p15", int'(bus.pc_o), 115);

    jump_to(127);
    step();
    chk("wrap127", int'(bus.pc_o), 0);
    jump_to(2);
    bus.branch_taken_i = 1'b1; bus.branch_off_i = 5'b11100;
    step();
    idle_ctl();
    chk("br_under", int'(bus.pc_o), 126);
    bus.branch_taken_i = 1'b1; bus.branch_off_i = 5'b00101;
    step();
    idle_ctl();
    chk("br_over", int'(bus.pc_o), 3);

    jump_to(40);
    bus.stall_i = 1'b1; bus.jump_en_i = 1'b1; bus.jump_target_i = 7'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("stall%0d", i), 40, 1, 0);
    end
    idle_ctl();
    step();
    chk("post_stall", int'(bus.pc_o), 41);

    jump_to(40);
    bus.stall_i = 1'b1; bus.halt_i = 1'b1;
    step();
    idle_ctl();
    check_state("halt_stall", 40, 0, 1);
    step();
    check_state("done_hold", 40, 0, 1);

    bus.start_i = 1'b1; bus.start_addr_i = 7'd64;
    step();
    idle_ctl();
    check_state("restart64", 64, 1, 0);
    bus.start_i = 1'b1; bus.start_addr_i = 7'd5;
    step();
    idle_ctl();
    check_state("start_in_run", 65, 1, 0);

    jump_to(77);
    chk("at77", int'(bus.pc_o), 77);
    reset_i = 1'b1; bus.jump_en_i = 1'b1; bus.jump_target_i = 7'd33;
    step();
    reset_i = 1'b0;
    idle_ctl();
    check_state("reset_mid", 0, 0, 0);

    // Six RUN cycles, the last one carrying halt.
    bus.start_i = 1'b1; bus.start_addr_i = 7'd0;
    step();
    idle_ctl();
`ifdef PC_FETCH_CYCLE_COUNT_EN
    chk("cnt_clr", int'(cycle_cnt_o), 0);
`endif
    for (int i = 0; i < 5; i++) step();
    chk("run5_pc", int'(bus.pc_o), 5);
    bus.halt_i = 1'b1;
    step();
    idle_ctl();
    check_state("run6_halt", 5, 0, 1);
`ifdef PC_FETCH_CYCLE_COUNT_EN
    chk("cnt6", int'(cycle_cnt_o), 6);
    step();
    step();
    chk("cnt6_hold", int'(cycle_cnt_o), 6);
    bus.start_i = 1'b1; bus.start_addr_i = 7'd3;
    step();
    idle_ctl();
    chk("cnt_restart", int'(cycle_cnt_o), 0);
    step();
    chk("cnt_one", int'(cycle_cnt_o), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
